matrix_reader: RTL and testbench
================================

Name: matrix_reader

Overview:
- Reads one stored matrix block from the shared matrix BRAM and returns its metadata plus an element stream to downstream compute/UART stages.
- Sits directly downstream of the matrix writer and consumes the block layout that the writer produces:
  - Block base = matrix_id*BLOCK_SIZE.
  - Word0 = {rows[31:24], cols[23:16], 16'd0}.
  - Word1 = name[31:0].
  - Word2 = name[63:32].
  - Data starts at base+3, row-major, rows*cols words.
- Uses a pipelined read with a credit-limited skid FIFO, so the stream sustains one word per cycle under arbitrary consumer backpressure.

Parameters:
- MAX_MEMORY_MATRIXES, 8, number of matrix blocks.
- BLOCK_SIZE, 1152, words per block, including 3 metadata words.
- DATA_WIDTH, 32, BRAM/data word width.
- ADDR_WIDTH, 14, BRAM address width.
- READ_LATENCY, 1, cycles from bram_rd_en/bram_addr to valid bram_dout (1..3).
- FIFO_DEPTH, 4, output skid FIFO entries; must be >= READ_LATENCY+1.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- read_req  in  1  start request; sampled only while reader_ready=1.
- matrix_id  in  3  block to read; latched with read_req.
- reader_ready  out  1  idle and able to accept read_req.
- meta_valid  out  1  one-cycle pulse; rows/cols/matrix_name are valid from this cycle until the next accepted read_req.
- rows  out  8  stored row count.
- cols  out  8  stored column count.
- matrix_name  out  64  stored name.
- data_out  out  DATA_WIDTH  element word.
- data_valid  out  1  data_out valid.
- data_ready  in  1  consumer accepts data_out; a transfer occurs when data_valid & data_ready.
- data_last  out  1  high with the final element (index rows*cols-1).
- read_done  out  1  one-cycle pulse at completion.
- read_error  out  1  set with read_done on failure; held until the next accepted read_req.
- bram_rd_en  out  1  BRAM read enable.
- bram_addr  out  ADDR_WIDTH  BRAM read address.
- bram_dout  in  DATA_WIDTH  BRAM read data, valid READ_LATENCY cycles after issue.

Behaviour:
- Reset values: all outputs 0 except reader_ready=1. The FIFO is emptied, in-flight tracking is cleared, and the FSM returns to IDLE.
  - A reset mid-read aborts the read with no read_done pulse; any read data returning after reset is ignored.
- IDLE: reader_ready=1.
  - read_req=1 latches matrix_id, clears read_error, and drops reader_ready the next cycle.
  - If matrix_id >= MAX_MEMORY_MATRIXES, go to DONE with read_error=1 and issue no reads.
  - read_req while not in IDLE is ignored.
- META_RD: issues base, base+1, base+2 on 3 consecutive cycles with bram_rd_en=1.
- META_WAIT: captures returning words by a latency-matched valid shift register, READ_LATENCY deep.
  - After word2 is captured: rows, cols, matrix_name are updated; meta_valid pulses the next cycle; total = rows*cols (16-bit).
  - total==0: go to DONE with read_error=0 and no data beats.
  - total > BLOCK_SIZE-3: go to DONE with read_error=1 and no data beats.
  - Otherwise go to DATA.
- DATA: issues reads from base+3 upward, one address per cycle, only while fifo_count + inflight < FIFO_DEPTH and issued < total.
  - Returned words are pushed into the FIFO. data_valid = FIFO not empty, and data_out is the FIFO head.
  - data_last is driven from a separate delivered counter (delivered == total-1).
  - After total reads have been issued, issuing stops; remain in DATA until the delivered count reaches total.
- DONE: read_done=1 for one cycle; return to IDLE with reader_ready=1 the following cycle.
- Zero-bubble requirement: with data_ready held high, consecutive beats occur on consecutive cycles.
  - Total cycles from read_req acceptance to read_done ≈ 3 + READ_LATENCY + 1 + total + READ_LATENCY + 2.
- Simultaneous FIFO push and pop on a full FIFO is legal; the credit rule guarantees no overflow.
- Counters are 11 bits minimum. Address arithmetic is ADDR_WIDTH bits; the top block ends exactly at 8*1152-1=9215 with no wrap.

Decomposition:
- Shared package matrix_bram_pkg holds:
  - META_WORDS=3.
  - Field offsets ROWS_MSB=31, COLS_MSB=23.
  - function block_base(id).
  - The enum for reader states: IDLE, META_RD, META_WAIT, DATA, DONE.
  - The writer should also use this package.
- One sub-module, matrix_read_fifo: synchronous FIFO, DATA_WIDTH x FIFO_DEPTH, with push/pop/count/empty/full ports.

Test Plan:
- Writer stores id=2 as 3x4 "MATRIX_A" with data 1..12; reader with id=2, data_ready=1 -> meta_valid with rows=3, cols=4, name matches; 12 beats 1..12 on consecutive cycles; data_last on beat 12; read_done one cycle later; read_error=0.
- Same matrix with data_ready toggled 1,0,0,1 repeatedly, at READ_LATENCY=1 and at 3 -> values 1..12 in order, no drop or duplicate, FIFO never overflows (assertion).
- Metadata word 0x0000_0000 (0x0) -> meta_valid with rows=0, cols=0; no data_valid; read_done; read_error=0.
- Metadata rows=255, cols=255 -> read_done with read_error=1; no data beats; no bram_rd_en beyond base+2.
- id=7 full 33x34 (1122 words) -> last address issued is 7*1152+3+1121=9188; data_last on beat 1122.
- Assert rst_n low mid-DATA after 5 beats -> all outputs return to reset values; next read_req id=2 returns the full 12-beat stream correctly.

Source files
------------

// File: rtl/matrix_bram_pkg.sv
// Shared layout definitions for matrix blocks in the matrix BRAM.
// Both the writer and the reader take block geometry and header field positions from here.
package matrix_bram_pkg;

    localparam int META_WORDS = 3;
    localparam int ROWS_MSB   = 31;
    localparam int COLS_MSB   = 23;

    typedef enum logic [2:0] {
        IDLE,
        META_RD,
        META_WAIT,
        DATA,
        DONE
    } rd_state_e;

    function automatic int block_base(input int id, input int block_size);
        return id * block_size;
    endfunction

endpackage

// File: rtl/matrix_read_fifo.sv
// Synchronous skid FIFO for the reader's element stream.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module matrix_read_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0]      count,
    output logic                  empty,
    output logic                  full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  do_push, do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/matrix_reader.sv
// Reads one matrix block (3 header words + row-major elements) from the matrix BRAM
// and streams the elements through a credit-limited skid FIFO.
//
// state     | meaning
// IDLE      | reader_ready=1, waiting for read_req
// META_RD   | issuing the three header reads
// META_WAIT | waiting for header words; decides DATA or DONE
// DATA      | issuing element reads under FIFO credit, draining to consumer
// DONE      | one-cycle read_done pulse
module matrix_reader
    import matrix_bram_pkg::*;
#(
    parameter int MAX_MEMORY_MATRIXES = 8,
    parameter int BLOCK_SIZE          = 1152,
    parameter int DATA_WIDTH          = 32,
    parameter int ADDR_WIDTH          = 14,
    parameter int READ_LATENCY        = 1,
    parameter int FIFO_DEPTH          = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  read_req,
    input  logic [2:0]            matrix_id,
    output logic                  reader_ready,
    output logic                  meta_valid,
    output logic [7:0]            rows,
    output logic [7:0]            cols,
    output logic [63:0]           matrix_name,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  data_last,
    output logic                  read_done,
    output logic                  read_error,
    output logic                  bram_rd_en,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    input  logic [DATA_WIDTH-1:0] bram_dout
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    rd_state_e               state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [1:0]              meta_iss_q, meta_iss_d, meta_cap_q, meta_cap_d;
    logic [READ_LATENCY-1:0] vld_sr_q, vld_sr_d;
    logic [15:0]             meta_rc_q, meta_rc_d;
    logic [31:0]             w1_q, w1_d;
    logic [7:0]              rows_q, rows_d, cols_q, cols_d;
    logic [63:0]             name_q, name_d;
    logic [15:0]             total_q, total_d, issued_q, issued_d, delivered_q, delivered_d;
    logic                    meta_valid_q, meta_valid_d, read_error_q, read_error_d;
    logic                    issue, ret_vld, push, pop, credit_ok;
    logic                    fifo_empty, fifo_full;
    logic [CNT_W-1:0]        fifo_count;
    logic [DATA_WIDTH-1:0]   fifo_head;
    logic [15:0]             meta_total;

    assign ret_vld = vld_sr_q[READ_LATENCY-1];
    assign push    = ret_vld && (state_q == DATA);
    assign pop     = !fifo_empty && data_ready;

    // The slot freed by this cycle's pop counts as credit, which keeps the
    // stream bubble-free even when FIFO_DEPTH is only READ_LATENCY+1.
    assign credit_ok = !(fifo_full && !pop) &&
                       ((int'(fifo_count) + $countones(vld_sr_q) - int'(pop)) < FIFO_DEPTH);

    matrix_read_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (bram_dout),
        .pop       (pop),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        meta_iss_d   = meta_iss_q;
        meta_cap_d   = meta_cap_q;
        meta_rc_d    = meta_rc_q;
        w1_d         = w1_q;
        rows_d       = rows_q;
        cols_d       = cols_q;
        name_d       = name_q;
        total_d      = total_q;
        issued_d     = issued_q;
        delivered_d  = delivered_q;
        read_error_d = read_error_q;
        meta_valid_d = 1'b0;
        issue        = 1'b0;
        vld_sr_d     = '0;
        meta_total   = 16'(meta_rc_q[15:8]) * 16'(meta_rc_q[7:0]);

        case (state_q)
            IDLE: begin
                if (read_req) begin
                    addr_d       = ADDR_WIDTH'(block_base(int'(matrix_id), BLOCK_SIZE));
                    meta_iss_d   = '0;
                    meta_cap_d   = '0;
                    issued_d     = '0;
                    delivered_d  = '0;
                    read_error_d = 1'b0;
                    if (int'(matrix_id) >= MAX_MEMORY_MATRIXES) begin
                        read_error_d = 1'b1;
                        state_d      = DONE;
                    end else begin
                        state_d = META_RD;
                    end
                end
            end
            META_RD: begin
                issue      = 1'b1;
                addr_d     = addr_q + ADDR_WIDTH'(1);
                meta_iss_d = meta_iss_q + 2'd1;
                if (meta_iss_q == 2'd2) state_d = META_WAIT;
            end
            META_WAIT: ;
            DATA: begin
                if ((issued_q < total_q) && credit_ok) begin
                    issue    = 1'b1;
                    addr_d   = addr_q + ADDR_WIDTH'(1);
                    issued_d = issued_q + 16'd1;
                end
                if (pop) begin
                    delivered_d = delivered_q + 16'd1;
                    if (delivered_q == total_q - 16'd1) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Header words can start returning while META_RD is still issuing.
        if (ret_vld && (state_q == META_RD || state_q == META_WAIT)) begin
            meta_cap_d = meta_cap_q + 2'd1;
            case (meta_cap_q)
                2'd0:    meta_rc_d = {bram_dout[ROWS_MSB -: 8], bram_dout[COLS_MSB -: 8]};
                2'd1:    w1_d = bram_dout[31:0];
                default: begin
                    rows_d       = meta_rc_q[15:8];
                    cols_d       = meta_rc_q[7:0];
                    name_d       = {bram_dout[31:0], w1_q};
                    total_d      = meta_total;
                    meta_valid_d = 1'b1;
                    if (meta_total == 16'd0) begin
                        state_d = DONE;
                    end else if (32'(meta_total) > BLOCK_SIZE - META_WORDS) begin
                        read_error_d = 1'b1;
                        state_d      = DONE;
                    end else begin
                        state_d = DATA;
                    end
                end
            endcase
        end

        vld_sr_d[0] = issue;
        for (int i = 1; i < READ_LATENCY; i++) vld_sr_d[i] = vld_sr_q[i-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            meta_iss_q   <= '0;
            meta_cap_q   <= '0;
            vld_sr_q     <= '0;
            meta_rc_q    <= '0;
            w1_q         <= '0;
            rows_q       <= '0;
            cols_q       <= '0;
            name_q       <= '0;
            total_q      <= '0;
            issued_q     <= '0;
            delivered_q  <= '0;
            meta_valid_q <= 1'b0;
            read_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            meta_iss_q   <= meta_iss_d;
            meta_cap_q   <= meta_cap_d;
            vld_sr_q     <= vld_sr_d;
            meta_rc_q    <= meta_rc_d;
            w1_q         <= w1_d;
            rows_q       <= rows_d;
            cols_q       <= cols_d;
            name_q       <= name_d;
            total_q      <= total_d;
            issued_q     <= issued_d;
            delivered_q  <= delivered_d;
            meta_valid_q <= meta_valid_d;
            read_error_q <= read_error_d;
        end
    end

    assign reader_ready = (state_q == IDLE);
    assign read_done    = (state_q == DONE);
    assign read_error   = read_error_q;
    assign meta_valid   = meta_valid_q;
    assign rows         = rows_q;
    assign cols         = cols_q;
    assign matrix_name  = name_q;
    assign bram_rd_en   = issue;
    assign bram_addr    = addr_q;
    assign data_valid   = !fifo_empty;
    assign data_out     = fifo_head;
    assign data_last    = !fifo_empty && (state_q == DATA) && (delivered_q == total_q - 16'd1);

endmodule

// File: tb/tb_matrix_reader.sv
// Bench for matrix_reader: two instances (read latency 1 and 3) on a behavioural BRAM,
// element stream checked against a queue of expected {last, data} beats.
`timescale 1ns/1ps
module tb_matrix_reader;

    localparam int BS = 1152;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        read_req [2];
    logic [2:0]  matrix_id [2];
    logic        data_ready [2];
    logic        reader_ready [2], meta_valid [2], data_valid [2], data_last [2];
    logic        read_done [2], read_error [2], bram_rd_en [2];
    logic [7:0]  rows [2], cols [2];
    logic [63:0] name [2];
    logic [31:0] data_out [2], bram_dout [2];
    logic [13:0] bram_addr [2];

    matrix_reader dut0 (
        .clk(clk), .rst_n(rst_n), .read_req(read_req[0]), .matrix_id(matrix_id[0]),
        .reader_ready(reader_ready[0]), .meta_valid(meta_valid[0]), .rows(rows[0]),
        .cols(cols[0]), .matrix_name(name[0]), .data_out(data_out[0]),
        .data_valid(data_valid[0]), .data_ready(data_ready[0]), .data_last(data_last[0]),
        .read_done(read_done[0]), .read_error(read_error[0]), .bram_rd_en(bram_rd_en[0]),
        .bram_addr(bram_addr[0]), .bram_dout(bram_dout[0])
    );

    matrix_reader #(.READ_LATENCY(3), .FIFO_DEPTH(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .read_req(read_req[1]), .matrix_id(matrix_id[1]),
        .reader_ready(reader_ready[1]), .meta_valid(meta_valid[1]), .rows(rows[1]),
        .cols(cols[1]), .matrix_name(name[1]), .data_out(data_out[1]),
        .data_valid(data_valid[1]), .data_ready(data_ready[1]), .data_last(data_last[1]),
        .read_done(read_done[1]), .read_error(read_error[1]), .bram_rd_en(bram_rd_en[1]),
        .bram_addr(bram_addr[1]), .bram_dout(bram_dout[1])
    );

    logic [31:0] mem [0:16383];
    logic [31:0] p0;
    logic [31:0] p1 [3];

    always @(posedge clk) begin
        p0    <= bram_rd_en[0] ? mem[bram_addr[0]] : 32'hDEAD_BEEF;
        p1[0] <= bram_rd_en[1] ? mem[bram_addr[1]] : 32'hDEAD_BEEF;
        p1[1] <= p1[0];
        p1[2] <= p1[1];
    end
    assign bram_dout[0] = p0;
    assign bram_dout[1] = p1[2];

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q [$];

    int cyc_g = 0;
    int beats, first_beat, last_beat, data_issued, popped, max_out, meta_pulses;
    int cur_base, last_addr, done_cyc;
    logic [7:0]  m_rows, m_cols;
    logic [63:0] m_name;
    logic        done_seen, err_seen;
    logic [3:0]  pat = 4'b1001;
    logic [63:0] nm_a = "MATRIX_A";
    logic [63:0] nm_b = "BIGBLOCK";

    always @(posedge clk) cyc_g <= cyc_g + 1;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [32:0] got, want;
        for (int d = 0; d < 2; d++) begin
            if (bram_rd_en[d]) begin
                last_addr = int'(bram_addr[d]);
                if (int'(bram_addr[d]) >= cur_base + 3) data_issued++;
            end
            if (data_valid[d] && data_ready[d]) begin
                got = {data_last[d], data_out[d]};
                if (exp_q.size() > 0) want = exp_q.pop_front();
                else want = '1;
                check64("beat", 64'(got), 64'(want));
                beats++;
                popped++;
                if (beats == 1) first_beat = cyc_g;
                last_beat = cyc_g;
            end
            if (data_issued - popped > max_out) max_out = data_issued - popped;
            if (meta_valid[d]) begin
                meta_pulses++;
                m_rows = rows[d];
                m_cols = cols[d];
                m_name = name[d];
            end
            if (read_done[d] && !done_seen) begin
                done_seen = 1'b1;
                err_seen  = read_error[d];
                done_cyc  = cyc_g;
            end
        end
    end

    task automatic write_matrix(input int id, input int r, input int c,
                                input logic [63:0] nm, input logic [31:0] first);
        int b;
        b = id * BS;
        mem[b]     = {8'(r), 8'(c), 16'd0};
        mem[b + 1] = nm[31:0];
        mem[b + 2] = nm[63:32];
        if (r * c <= BS - 3)
            for (int k = 0; k < r * c; k++) mem[b + 3 + k] = first + 32'(k);
    endtask

    task automatic push_expected(input int n, input logic [31:0] first);
        for (int k = 0; k < n; k++) exp_q.push_back({(k == n - 1), first + 32'(k)});
    endtask

    task automatic clear_stats(input int base);
        cur_base = base; beats = 0; data_issued = 0; popped = 0; max_out = 0;
        meta_pulses = 0; done_seen = 1'b0; err_seen = 1'b0; last_addr = -1;
        first_beat = 0; last_beat = 0; done_cyc = 0;
    endtask

    task automatic do_read(input int d, input int id, input bit toggle);
        clear_stats(id * BS);
        @(posedge clk); #1;
        matrix_id[d]  = 3'(id);
        read_req[d]   = 1'b1;
        data_ready[d] = 1'b1;
        @(posedge clk); #1;
        read_req[d] = 1'b0;
        for (int n = 0; n < 3000 && !done_seen; n++) begin
            data_ready[d] = toggle ? pat[n % 4] : 1'b1;
            @(posedge clk); #1;
        end
        data_ready[d] = 1'b0;
        check("done_seen", int'(done_seen), 1);
    endtask

    task automatic check_idle_outputs(input int d, input string tag);
        check({tag, "_ready"}, int'(reader_ready[d]), 1);
        check({tag, "_flags"}, int'({meta_valid[d], data_valid[d], data_last[d],
                                     read_done[d], read_error[d], bram_rd_en[d]}), 0);
        check({tag, "_rowscols"}, int'({rows[d], cols[d]}), 0);
        check64({tag, "_name"}, name[d], 64'd0);
        check({tag, "_data_out"}, int'(data_out[d]), 0);
        check({tag, "_addr"}, int'(bram_addr[d]), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            read_req[d] = 1'b0; matrix_id[d] = 3'd0; data_ready[d] = 1'b0;
        end
        for (int i = 0; i < 16384; i++) mem[i] = 32'hA5A5_0000 ^ 32'(i);
        write_matrix(2, 3, 4, nm_a, 32'd1);
        mem[3 * BS] = 32'h0000_0000;
        write_matrix(4, 255, 255, nm_a, 32'd0);
        write_matrix(7, 33, 34, nm_b, 32'h7000_0000);
        clear_stats(0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs(0, "rst0");
        check_idle_outputs(1, "rst1");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 3x4 matrix, consumer always ready
        push_expected(12, 32'd1);
        do_read(0, 2, 1'b0);
        check("t1_meta_pulses", meta_pulses, 1);
        check("t1_rows", int'(m_rows), 3);
        check("t1_cols", int'(m_cols), 4);
        check64("t1_name", m_name, nm_a);
        check("t1_beats", beats, 12);
        check("t1_back_to_back", last_beat - first_beat, 11);
        check("t1_done_after_last", done_cyc - last_beat, 1);
        check("t1_error", int'(err_seen), 0);
        check("t1_queue_left", exp_q.size(), 0);

        // backpressure pattern 1,0,0,1 at both latencies
        for (int d = 0; d < 2; d++) begin
            push_expected(12, 32'd1);
            do_read(d, 2, 1'b1);
            check("t2_beats", beats, 12);
            check("t2_queue_left", exp_q.size(), 0);
            check("t2_no_overflow", int'(max_out <= 4), 1);
            check("t2_error", int'(err_seen), 0);
        end

        // empty matrix header
        do_read(0, 3, 1'b0);
        check("t3_meta_pulses", meta_pulses, 1);
        check("t3_rowscols", int'({m_rows, m_cols}), 0);
        check("t3_beats", beats, 0);
        check("t3_data_reads", data_issued, 0);
        check("t3_error", int'(err_seen), 0);

        // oversized header
        do_read(1, 4, 1'b0);
        check("t4_rows", int'(m_rows), 255);
        check("t4_beats", beats, 0);
        check("t4_data_reads", data_issued, 0);
        check("t4_error", int'(err_seen), 1);

        // top block, 33x34
        push_expected(1122, 32'h7000_0000);
        do_read(0, 7, 1'b0);
        check("t5_beats", beats, 1122);
        check("t5_last_addr", last_addr, 9188);
        check("t5_back_to_back", last_beat - first_beat, 1121);
        check("t5_queue_left", exp_q.size(), 0);
        check("t5_error", int'(err_seen), 0);

        // reset in the middle of the data phase
        push_expected(12, 32'd1);
        clear_stats(2 * BS);
        @(posedge clk); #1;
        matrix_id[0] = 3'd2; read_req[0] = 1'b1; data_ready[0] = 1'b1;
        @(posedge clk); #1;
        read_req[0] = 1'b0;
        for (int n = 0; n < 200 && beats < 5; n++) begin
            @(posedge clk); #1;
        end
        check("t6_beats_before_reset", beats, 5);
        rst_n = 1'b0;
        data_ready[0] = 1'b0;
        #1;
        check_idle_outputs(0, "t6_rst");
        exp_q.delete();
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("t6_no_done", int'(done_seen), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        push_expected(12, 32'd1);
        do_read(0, 2, 1'b0);
        check("t6_rows", int'(m_rows), 3);
        check("t6_beats", beats, 12);
        check("t6_queue_left", exp_q.size(), 0);
        check("t6_error", int'(err_seen), 0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
